// File: rtl/mdu_hilo_if.sv
// Request/response bundle between the CPU control unit and the HI/LO multiply-divide unit.
interface mdu_hilo_if;
  localparam int unsigned W = 32;

  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// Multi-cycle 32-bit multiply/divide unit owning the HI/LO pair.
// One radix-2 step per cycle: shift-add multiply, restoring divide.
module mdu_hilo (
  input logic       clk,
  input logic       rst_n,
  mdu_hilo_if.slave bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic           neg_a_q, neg_a_d;
  logic           neg_b_q, neg_b_d;
  logic           divz_q, divz_d;
  logic [W-1:0]   a_raw_q, a_raw_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;

  logic           sgn_c;
  logic [W-1:0]   abs_a_c, abs_b_c;
  logic [W:0]     mul_sum_c;
  logic [W:0]     trial_c;
  logic           div_ok_c;
  logic [W-1:0]   rem_sub_c;
  logic [2*W-1:0] step_c;
  logic [2*W-1:0] prod_c;
  logic [W-1:0]   quo_c, rem_c;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Operand magnitudes for the signed ops (MULT=0, DIV=2).
  always_comb begin
    sgn_c   = (bus.op == 3'd0) || (bus.op == 3'd2);
    abs_a_c = (sgn_c && bus.a[W-1]) ? (~bus.a + W'(1)) : bus.a;
    abs_b_c = (sgn_c && bus.b[W-1]) ? (~bus.b + W'(1)) : bus.b;
  end

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum_c = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    trial_c   = acc_q[2*W-1:W-1];
    div_ok_c  = (trial_c >= {1'b0, opnd_q});
    rem_sub_c = trial_c[W-1:0] - opnd_q;
    if (is_div_q) begin
      step_c = {(div_ok_c ? rem_sub_c : trial_c[W-1:0]), acc_q[W-2:0], div_ok_c};
    end else begin
      step_c = {mul_sum_c, acc_q[W-1:1]};
    end
    prod_c = (neg_a_q ^ neg_b_q) ? (~step_c + (2*W)'(1)) : step_c;
    quo_c  = (neg_a_q ^ neg_b_q) ? (~step_c[W-1:0] + W'(1)) : step_c[W-1:0];
    rem_c  = neg_a_q ? (~step_c[2*W-1:W] + W'(1)) : step_c[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      divz_q   <= 1'b0;
      a_raw_q  <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      divz_q   <= divz_d;
      a_raw_q  <= a_raw_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    divz_d   = divz_q;
    a_raw_d  = a_raw_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              is_div_d = bus.op[1];
              neg_a_d  = sgn_c & bus.a[W-1];
              neg_b_d  = sgn_c & bus.b[W-1];
              divz_d   = (bus.b == '0);
              a_raw_d  = bus.a;
              opnd_d   = bus.op[1] ? abs_b_c : abs_a_c;
              acc_d    = {W'(0), (bus.op[1] ? abs_a_c : abs_b_c)};
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = CALC;
            end
            3'd4: begin
              hi_d   = bus.a;
              done_d = 1'b1;
            end
            3'd5: begin
              lo_d   = bus.a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      CALC: begin
        acc_d = step_c;
        cnt_d = cnt_q + CW'(1);
        // Last step: sign-correct and publish in the same edge.
        if (cnt_q == CW'(W-1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_c[2*W-1:W];
            lo_d = prod_c[W-1:0];
          end else if (divz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_c;
            lo_d = quo_c;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed vector bench for mdu_hilo: latency, results, corner sequences.
module tb_mdu_hilo;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mdu_hilo_if bus ();

  mdu_hilo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // cyc0 is the cycle index (relative to the start cycle) at entry.
  task automatic wait_done(input string name, input int cyc0,
                           input logic [31:0] eh, input logic [31:0] el);
    int cyc;
    int bcnt;
    cyc  = cyc0;
    bcnt = cyc0 - 1 + (bus.busy ? 1 : 0);
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) bcnt++;
    end
    check({name, "_latency"}, 64'(cyc), 64'd33);
    check({name, "_busy_cycles"}, 64'(bcnt), 64'd32);
    check({name, "_hi"}, 64'(bus.hi), 64'(eh));
    check({name, "_lo"}, 64'(bus.lo), 64'(el));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dcnt;

    vt[0] = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vt[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[2] = '{3'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vt[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[4] = '{3'd2, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
    vt[5] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vt[6] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vt[7] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vt[8] = '{3'd0, 32'h0000_3039, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7};
    vt[9] = '{3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      launch(vt[i].op, vt[i].a, vt[i].b);
      wait_done($sformatf("vec%0d", i), 1, vt[i].hi, vt[i].lo);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
    end

    // DIV then DIVU launched in the done cycle
    launch(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div_m7_2", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    launch(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("divu_b2b", 1, 32'h0000_0001, 32'h7FFF_FFFC);
    @(negedge clk);

    // Reserved op is ignored
    launch(3'd6, 32'h1111_1111, 32'h2222_2222);
    check("rsv_busy", 64'(bus.busy), 64'd0);
    check("rsv_done", 64'(bus.done), 64'd0);
    check("rsv_hi", 64'(bus.hi), 64'h0000_0001);
    check("rsv_lo", 64'(bus.lo), 64'h7FFF_FFFC);

    // MTHI
    launch(3'd4, 32'hDEAD_BEEF, 32'h0);
    check("mthi_done", 64'(bus.done), 64'd1);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    check("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
    check("mthi_lo", 64'(bus.lo), 64'h7FFF_FFFC);
    @(negedge clk);
    check("mthi_done_pulse", 64'(bus.done), 64'd0);

    // MULT 7 x -3 with an MTLO request and operand changes while busy
    launch(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
    check("mult_busy_c1", 64'(bus.busy), 64'd1);
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.a     = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'd1;
    repeat (2) @(negedge clk);
    check("mtlo_ignored_lo", 64'(bus.lo), 64'h7FFF_FFFC);
    check("mult_busy_c4", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.a  = 32'h0000_FFFF;
    bus.b  = 32'h0000_FFFF;
    bus.op = 3'd0;
    wait_done("mult_latched", 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(negedge clk);

    // Reset in cycle 10 of a MULTU
    launch(3'd1, 32'h0001_0000, 32'h0001_0000);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_hi", 64'(bus.hi), 64'd0);
    check("midrst_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    dcnt  = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("midrst_no_done", 64'(dcnt), 64'd0);
    launch(3'd1, 32'h0001_0000, 32'h0001_0000);
    wait_done("after_rst", 1, 32'h0000_0001, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO register pair for the 54-instruction single-cycle CPU.
- Handles MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- The combinational ALU cannot do these in one cycle, so this unit does them. The control unit launches an operation with start and stalls the PC while busy=1.
- MFHI/MFLO read the hi/lo ports directly.

Parameters:
- none. The datapath is fixed at 32 bits to match the register file.

Ports:
- clk    in   1   system clock, rising edge
- rst_n  in   1   synchronous active-low reset
- start  in   1   launch the operation in op; sampled only when busy=0
- op     in   3   0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved
- a      in   32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b      in   32  rt operand (divisor / multiplier)
- busy   out  1   operation in progress; control stalls the CPU while high
- done   out  1   one-cycle pulse; asserted in the same cycle that new hi/lo values are visible
- hi     out  32  HI register
- lo     out  32  LO register

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: on any rising edge with rst_n=0:
  - state=IDLE
  - busy=0, done=0, hi=0, lo=0
  - iteration counter=0
  - Any in-flight operation is aborted with no done pulse.
- States: IDLE and CALC.
- IDLE:
  - done is cleared every cycle unless set by the rules below.
  - start=1 with op 0-3 (start seen in cycle N):
    - latch a, b and op
    - form the absolute values of a and b for signed ops
    - clear the partial product/remainder and set counter=0
    - go to CALC; busy=1 from cycle N+1
  - start=1 with op 4 (MTHI): hi<=a at the end of cycle N; lo unchanged; done=1 in cycle N+1; busy stays 0.
  - start=1 with op 5 (MTLO): the same, but writes lo.
  - start=1 with op 6/7: ignored; no state change, no done.
- CALC: exactly 32 cycles, N+1..N+32. Each cycle is one radix-2 step and counter increments.
  - Multiply: shift-add over a 64-bit accumulator on the unsigned magnitudes.
  - Divide: restoring division. Each step shifts the remainder left by one, brings in the next dividend bit, subtracts the divisor when the result is non-negative (33-bit compare), and shifts in the quotient bit.
  - When counter=31, apply sign correction combinationally and register the result on the same edge:
    - busy<=0, done<=1, state<=IDLE
    - hi/lo take the new values
    - done is high in cycle N+33.
- Sign rules:
  - MULT: negate the 64-bit product when a[31]^b[31].
  - DIV: negate the quotient when a[31]^b[31]; the remainder takes the sign of a.
  - Unsigned ops use the raw magnitudes.
- Results:
  - MULT/MULTU: hi=product[63:32], lo=product[31:0].
  - DIV/DIVU: lo=quotient, hi=remainder.
- Divide by zero (b=0, signed or unsigned):
  - lo=0xFFFFFFFF, hi=a (raw latched value); no sign correction applied.
  - Same 32-cycle latency.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of 32-bit magnitude arithmetic; no special casing needed beyond correct widths.
- Inputs while busy:
  - start is ignored while busy=1, including an MTHI/MTLO request.
  - Changes on a, b or op during CALC have no effect; operands are latched.
- Back-to-back: start in cycle N+33, where done=1 and busy=0, is accepted.
- hi and lo hold their values at all times except on the documented writes.
- Mid-operation reset: abort as in the Reset rule; no done pulse.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=0x00000003, start at cycle 0 -> busy high in cycles 1-32; done=1 in cycle 33 with hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 in cycle 33.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU with the same operands, started in the done cycle -> lo=0x7FFFFFFC, hi=0x00000001.
- Divide edge cases:
  - DIVU a=0x00001234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF while idle -> hi=0xDEADBEEF and done=1 next cycle, lo unchanged, busy never high. During a following MULT:
  - pulse start with MTLO
  - change a and b at cycle 5
  - required: both ignored; the MULT result reflects the latched operands.
- Start MULTU 0x10000 x 0x10000, drive rst_n=0 in cycle 10 -> after the next edge busy=0, hi=lo=0, no done pulse; a new op afterwards completes normally.
